// File: rtl/tt_subtractor_pkg.sv
// Shared types and pin map for the serial subtractor tile.
package tt_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // uio_in strobe positions
    localparam int PIN_LOAD_A = 0;
    localparam int PIN_LOAD_B = 1;
    localparam int PIN_START  = 2;

    // uio_out status positions
    localparam int PIN_BUSY   = 4;
    localparam int PIN_DONE   = 5;
    localparam int PIN_BORROW = 6;
    localparam int PIN_ZERO   = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference and borrow of x - y.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/tt_um_ajah_stott_holmes_serial_subtractor.sv
// Bit-serial unsigned A - B, LSB first, built from two chained half subtractors.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting; operands may be loaded, start launches an operation
// ST_SHIFT | one difference bit per clock, strobes ignored
// ST_DONE  | result/borrow/zero valid; load returns to idle, start reruns
module tt_um_ajah_stott_holmes_serial_subtractor
    import tt_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_out;
    logic [CW-1:0]      r_cnt;
    logic               r_bin;
    logic               r_borrow;
    logic               r_zero;

    logic               w_load_a;
    logic               w_load_b;
    logic               w_load_any;
    logic               w_start_go;
    logic               w_shifting;
    logic               w_last;
    logic               w_d1;
    logic               w_b1;
    logic               w_d;
    logic               w_b2;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_nxt;
    logic [7:0]         w_uio_out;
    logic               w_unused;

    assign w_load_a   = uio_in[PIN_LOAD_A];
    assign w_load_b   = uio_in[PIN_LOAD_B];
    assign w_load_any = w_load_a | w_load_b;
    // A load in the same cycle always beats start.
    assign w_start_go = uio_in[PIN_START] & ~w_load_any;
    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    half_subtractor u_hs_ab (
        .x  (r_sh_a[0]),
        .y  (r_sh_b[0]),
        .d  (w_d1),
        .bo (w_b1)
    );

    half_subtractor u_hs_bin (
        .x  (w_d1),
        .y  (r_bin),
        .d  (w_d),
        .bo (w_b2)
    );

    assign w_bout    = w_b1 | w_b2;
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_load_any)      w_state_nxt = ST_IDLE;
                else if (w_start_go) w_state_nxt = ST_SHIFT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_res    <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else if (!w_shifting) begin
            if (w_load_a) r_a <= ui_in[WIDTH-1:0];
            if (w_load_b) r_b <= ui_in[WIDTH-1:0];
            if (w_start_go) begin
                r_sh_a <= r_a;
                r_sh_b <= r_b;
                r_bin  <= 1'b0;
                r_cnt  <= '0;
            end
        end else begin
            r_sh_a <= r_sh_a >> 1;
            r_sh_b <= r_sh_b >> 1;
            r_res  <= w_res_nxt;
            r_bin  <= w_bout;
            r_cnt  <= r_cnt + CW'(1);
            // Published outputs update only once, with the completed word.
            if (w_last) begin
                r_out    <= w_res_nxt;
                r_borrow <= w_bout;
                r_zero   <= (w_res_nxt == '0);
            end
        end
    end

    always_comb begin
        w_uio_out             = 8'h00;
        w_uio_out[PIN_BUSY]   = w_shifting;
        w_uio_out[PIN_DONE]   = (r_state == ST_DONE);
        w_uio_out[PIN_BORROW] = r_borrow;
        w_uio_out[PIN_ZERO]   = r_zero;
    end

    assign uo_out   = 8'(r_out);
    assign uio_out  = w_uio_out;
    assign uio_oe   = UIO_OE_VAL;
    assign w_unused = &{1'b0, ena, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_ajah_stott_holmes_serial_subtractor.sv
// Self-checking bench for the serial subtractor tile: vector table, hand sequences, random ops.
module tb_tt_um_ajah_stott_holmes_serial_subtractor;

    localparam int WIDTH = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_ajah_stott_holmes_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer subtraction wrapped into WIDTH bits.
    task automatic ref_sub(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] d, output logic bo, output logic z);
        int diff;
        diff = int'(a) - int'(b);
        bo   = (diff < 0);
        if (diff < 0) diff += (1 << WIDTH);
        d = 8'(diff);
        z = (d == 8'h00);
    endtask

    task automatic load(input logic la, input logic lb, input logic [7:0] v);
        @(negedge clk);
        ui_in  = v;
        uio_in = {6'b0, lb, la};
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        if (a == b) begin
            load(1'b1, 1'b1, a);
        end else begin
            load(1'b1, 1'b0, a);
            load(1'b0, 1'b1, b);
        end
    endtask

    // Polls at negedges until done, counting busy samples; bounded.
    task automatic wait_done(output int busy_cnt, output logic got_done);
        int i;
        busy_cnt = 0;
        got_done = 1'b0;
        i = 0;
        while (!got_done && i < 40) begin
            if (uio_out[5]) begin
                got_done = 1'b1;
            end else begin
                if (uio_out[4]) busy_cnt++;
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic run_op(output int busy_cnt, output logic got_done);
        @(negedge clk);
        uio_in = 8'b0000_0100;
        @(negedge clk);
        uio_in = 8'h00;
        wait_done(busy_cnt, got_done);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic bo,
                                input logic z, input int busy_cnt, input logic got_done);
        check({tag, "_done"},   got_done, 1);
        check({tag, "_busycnt"}, busy_cnt, WIDTH);
        check({tag, "_diff"},   uo_out, d);
        check({tag, "_borrow"}, uio_out[6], bo);
        check({tag, "_zero"},   uio_out[7], z);
        check({tag, "_busy0"},  uio_out[4], 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        logic       gd;
        logic [7:0] ra, rb, ed;
        logic       eb, ez;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h77, 8'h77, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};

        #23;
        check("rst_uo_out",  uo_out,  8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe",  uio_oe,  8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_uio_out", uio_out, 8'h00);

        for (int i = 0; i < 8; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            run_op(bc, gd);
            check_result($sformatf("vec%0d", i), vecs[i].diff, vecs[i].borrow,
                         vecs[i].zero, bc, gd);
            if (i == 0) begin
                repeat (3) @(negedge clk);
                check("hold_done", uio_out[5], 1);
                check("hold_diff", uo_out, vecs[0].diff);
            end
        end

        // Strobes during SHIFT are ignored and operands survive for a rerun.
        load_ab(8'hFF, 8'h01);
        @(negedge clk);
        uio_in = 8'b0000_0100;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        check("shift_busy3", uio_out[4], 1);
        ui_in  = 8'h00;
        uio_in = 8'b0000_0101;
        @(negedge clk);
        uio_in = 8'h00;
        wait_done(bc, gd);
        check("ign_done",   gd, 1);
        check("ign_diff",   uo_out, 8'hFE);
        check("ign_borrow", uio_out[6], 0);
        run_op(bc, gd);
        check_result("rerun", 8'hFE, 1'b0, 1'b0, bc, gd);

        // Load in DONE drops done but keeps the result; start+load: load wins.
        load(1'b1, 1'b0, 8'h03);
        check("load_clr_done", uio_out[5], 0);
        check("load_keep_diff", uo_out, 8'hFE);
        @(negedge clk);
        ui_in  = 8'h05;
        uio_in = 8'b0000_0110;
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        check("startload_busy", uio_out[4], 0);
        @(negedge clk);
        check("startload_busy2", uio_out[4], 0);
        run_op(bc, gd);
        check_result("after_sl", 8'hFE, 1'b1, 1'b0, bc, gd);

        // Start held high: a DONE state relaunches on the next edge.
        load_ab(8'h09, 8'h04);
        @(negedge clk);
        uio_in = 8'b0000_0100;
        @(negedge clk);
        wait_done(bc, gd);
        check("held_done", gd, 1);
        check("held_diff", uo_out, 8'h05);
        @(negedge clk);
        check("held_rebusy", uio_out[4], 1);
        check("held_redone", uio_out[5], 0);
        uio_in = 8'h00;
        wait_done(bc, gd);
        check("held2_done", gd, 1);
        check("held2_diff", uo_out, 8'h05);

        // Asynchronous reset in the middle of an operation.
        load_ab(8'h5A, 8'h3C);
        @(negedge clk);
        uio_in = 8'b0000_0100;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", uio_out[4], 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_uio_out", uio_out, 8'h00);
        check("arst_uo_out",  uo_out,  8'h00);
        check("arst_uio_oe",  uio_oe,  8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", uio_out, 8'h00);
        load_ab(8'h00, 8'h00);
        run_op(bc, gd);
        check_result("arst_op", 8'h00, 1'b0, 1'b1, bc, gd);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (n % 7 == 0) ? ra : 8'($urandom_range(0, 255));
            ref_sub(ra, rb, ed, eb, ez);
            load_ab(ra, rb);
            run_op(bc, gd);
            check_result($sformatf("rnd%0d_%02h_%02h", n, ra, rb), ed, eb, ez, bc, gd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
